// File: rtl/lcd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared opcodes, characters, line windows and address stepping
//               for the HD44780-compatible responder.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam logic [7:0] c_OP_CLEAR   = 8'h01;
    localparam logic [7:0] c_OP_HOME    = 8'h02;
    localparam logic [7:0] c_OP_ENTRY   = 8'h04;
    localparam logic [7:0] c_OP_DISPCTL = 8'h08;
    localparam logic [7:0] c_OP_SHIFT   = 8'h10;
    localparam logic [7:0] c_OP_FUNCSET = 8'h20;
    localparam logic [7:0] c_OP_CGRAM   = 8'h40;
    localparam logic [7:0] c_OP_DDRAM   = 8'h80;

    localparam logic [7:0] c_DIGIT_BASE = 8'h30;
    localparam logic [7:0] c_COLON      = 8'h3A;
    localparam logic [7:0] c_SPACE      = 8'h20;

    localparam logic [6:0] c_L1_END     = 7'h27;
    localparam logic [6:0] c_L2_START   = 7'h40;
    localparam logic [6:0] c_ONE_END    = 7'h4F;
    localparam logic [6:0] c_L2_END     = 7'h67;

    typedef enum logic [1:0] {
        ST_POWERUP = 2'd0,
        ST_IDLE    = 2'd1,
        ST_BUSY    = 2'd2,
        ST_FILL    = 2'd3
    } lcd_state_t;

    // Out-of-window addresses just step through the raw 7-bit space.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc,
                                             input logic two);
        logic [6:0] r;
        r = inc ? a + 7'd1 : a - 7'd1;
        if (two) begin
            if (inc && a == c_L1_END)         r = c_L2_START;
            else if (inc && a == c_L2_END)    r = 7'h00;
            else if (!inc && a == 7'h00)      r = c_L2_END;
            else if (!inc && a == c_L2_START) r = c_L1_END;
        end else begin
            if (inc && a == c_ONE_END)        r = 7'h00;
            else if (!inc && a == 7'h00)      r = c_ONE_END;
        end
        return r;
    endfunction

    function automatic logic addr_valid(input logic [6:0] a, input logic two);
        if (two) return (a <= c_L1_END) || (a >= c_L2_START && a <= c_L2_END);
        return a <= c_ONE_END;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_hd44780_responder_ddram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lcd_ddram
// Description : 128x8 display RAM, one write port, registered peek port and
//               combinational bus read port.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_ddram (
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] peek_addr,
    output logic [7:0] peek_data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] r_mem [128];
    logic [7:0] r_peek;

    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    // Same-cycle write/peek collision returns the pre-write contents.
    always_ff @(posedge clk) begin
        r_peek <= r_mem[peek_addr];
    end

    assign peek_data = r_peek;
    assign rd_data   = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/lcd_hd44780_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lcd_hd44780_responder
// Description : HD44780-compatible bus responder: strobe decode, command
//               execution, DDRAM, address counter, busy flag and read-back.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int E_MIN_CYCLES   = 12,
    parameter int BUSY_SHORT     = 2000,
    parameter int BUSY_LONG      = 76500,
    parameter int POWERUP_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_d,
    output logic [7:0] lcd_q,
    output logic       lcd_q_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       inc_mode,
    output logic       err,
    input  logic [6:0] peek_addr,
    output logic [7:0] peek_data
);

    localparam logic [31:0] c_SHORT_M1 = 32'(BUSY_SHORT - 1);
    localparam logic [31:0] c_LONG_M1  = 32'(BUSY_LONG - 1);
    localparam logic [31:0] c_PWR_LAST = 32'(POWERUP_CYCLES - 1);
    localparam logic [15:0] c_E_MIN    = 16'(E_MIN_CYCLES);

    lcd_state_t  r_state, w_state_nxt;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic [6:0]  r_fill, w_fill_nxt, r_ac, w_ac_nxt;
    logic        r_disp, r_cur, r_blink, r_two, r_inc, r_err;
    logic        w_disp_nxt, w_cur_nxt, w_blink_nxt, w_two_nxt, w_inc_nxt, w_err_nxt;
    logic        r_e_q, r_rs, r_rw;
    logic [7:0]  r_d;
    logic [15:0] r_ew;
    logic        w_fall, w_wide, w_idle;
    logic        w_we;
    logic [6:0]  w_waddr;
    logic [7:0]  w_wdata, w_rd_data, r_q;
    logic        r_q_oe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_q <= 1'b0;
            r_rs  <= 1'b0;
            r_rw  <= 1'b0;
            r_d   <= 8'h00;
            r_ew  <= 16'd0;
        end else begin
            r_e_q <= lcd_e;
            if (lcd_e) begin
                r_rs <= lcd_rs;
                r_rw <= lcd_rw;
                r_d  <= lcd_d;
                if (!r_e_q)                r_ew <= 16'd1;
                else if (r_ew != 16'hFFFF) r_ew <= r_ew + 16'd1;
            end
        end
    end

    assign w_fall = r_e_q & ~lcd_e;
    assign w_wide = (r_ew >= c_E_MIN);
    assign w_idle = (r_state == ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fill_nxt  = r_fill;
        w_ac_nxt    = r_ac;
        w_disp_nxt  = r_disp;
        w_cur_nxt   = r_cur;
        w_blink_nxt = r_blink;
        w_two_nxt   = r_two;
        w_inc_nxt   = r_inc;
        w_err_nxt   = r_err;
        w_we        = 1'b0;
        w_waddr     = r_ac;
        w_wdata     = r_d;

        case (r_state)
            ST_POWERUP: begin
                w_cnt_nxt = r_cnt + 32'd1;
                if (r_cnt < 32'd128) begin
                    w_we    = 1'b1;
                    w_waddr = r_cnt[6:0];
                    w_wdata = c_SPACE;
                end
                if (r_cnt == c_PWR_LAST) w_state_nxt = ST_IDLE;
            end
            ST_FILL: begin
                w_we       = 1'b1;
                w_waddr    = r_fill;
                w_wdata    = c_SPACE;
                w_fill_nxt = r_fill + 7'd1;
                w_cnt_nxt  = r_cnt - 32'd1;
                if (r_fill == 7'h7F) w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                w_cnt_nxt = r_cnt - 32'd1;
                if (r_cnt == 32'd0) w_state_nxt = ST_IDLE;
            end
            default: ;
        endcase

        if (w_fall) begin
            if (!w_wide) begin
                w_err_nxt = 1'b1;
            end else if (r_rw) begin
                if (r_rs) begin
                    if (w_idle) w_ac_nxt = step_addr(r_ac, r_inc, r_two);
                    else        w_err_nxt = 1'b1;
                end
            end else if (!w_idle) begin
                w_err_nxt = 1'b1;
            end else begin
                w_state_nxt = ST_BUSY;
                w_cnt_nxt   = c_SHORT_M1;
                if (r_rs) begin
                    w_we     = 1'b1;
                    w_waddr  = r_ac;
                    w_wdata  = r_d;
                    w_ac_nxt = step_addr(r_ac, r_inc, r_two);
                end else if ((r_d & c_OP_DDRAM) != 8'h00) begin
                    w_ac_nxt = r_d[6:0];
                    if (!addr_valid(r_d[6:0], r_two)) w_err_nxt = 1'b1;
                end else if ((r_d & c_OP_CGRAM) != 8'h00) begin
                end else if ((r_d & c_OP_FUNCSET) != 8'h00) begin
                    w_two_nxt = r_d[3];
                    if (!r_d[4]) w_err_nxt = 1'b1;
                end else if ((r_d & c_OP_SHIFT) != 8'h00) begin
                    if (!r_d[3]) w_ac_nxt = step_addr(r_ac, r_d[2], r_two);
                end else if ((r_d & c_OP_DISPCTL) != 8'h00) begin
                    w_disp_nxt  = r_d[2];
                    w_cur_nxt   = r_d[1];
                    w_blink_nxt = r_d[0];
                end else if ((r_d & c_OP_ENTRY) != 8'h00) begin
                    w_inc_nxt = r_d[1];
                end else if ((r_d & c_OP_HOME) != 8'h00) begin
                    w_ac_nxt  = 7'h00;
                    w_cnt_nxt = c_LONG_M1;
                end else if ((r_d & c_OP_CLEAR) != 8'h00) begin
                    w_state_nxt = ST_FILL;
                    w_fill_nxt  = 7'h00;
                    w_ac_nxt    = 7'h00;
                    w_inc_nxt   = 1'b1;
                    w_cnt_nxt   = c_LONG_M1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_POWERUP;
            r_cnt   <= 32'd0;
            r_fill  <= 7'h00;
            r_ac    <= 7'h00;
            r_disp  <= 1'b0;
            r_cur   <= 1'b0;
            r_blink <= 1'b0;
            r_two   <= 1'b0;
            r_inc   <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fill  <= w_fill_nxt;
            r_ac    <= w_ac_nxt;
            r_disp  <= w_disp_nxt;
            r_cur   <= w_cur_nxt;
            r_blink <= w_blink_nxt;
            r_two   <= w_two_nxt;
            r_inc   <= w_inc_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Read data follows RS/RW live while E is high so BF can be polled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= 8'h00;
            r_q_oe <= 1'b0;
        end else if (lcd_e && lcd_rw) begin
            r_q    <= lcd_rs ? w_rd_data : {busy, r_ac};
            r_q_oe <= 1'b1;
        end else begin
            r_q    <= 8'h00;
            r_q_oe <= 1'b0;
        end
    end

    lcd_ddram u_ddram (
        .clk       (clk),
        .we        (w_we),
        .waddr     (w_waddr),
        .wdata     (w_wdata),
        .peek_addr (peek_addr),
        .peek_data (peek_data),
        .rd_addr   (r_ac),
        .rd_data   (w_rd_data)
    );

    assign busy      = (r_state != ST_IDLE);
    assign ac        = r_ac;
    assign disp_on   = r_disp;
    assign cursor_on = r_cur;
    assign blink_on  = r_blink;
    assign two_line  = r_two;
    assign inc_mode  = r_inc;
    assign err       = r_err;
    assign lcd_q     = r_q;
    assign lcd_q_oe  = r_q_oe;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lcd_hd44780_responder
// Description : Randomized scoreboard bench for the HD44780 responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_hd44780_responder;
    import lcd_pkg::*;

    localparam int E_MIN = 4;
    localparam int BS    = 40;
    localparam int BL    = 300;
    localparam int PWR   = 200;

    logic       clk = 1'b0, rst = 1'b1;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_d = 8'h00;
    logic [6:0] peek_addr = 7'h00;
    logic [7:0] lcd_q, peek_data;
    logic       lcd_q_oe, busy, disp_on, cursor_on, blink_on, two_line, inc_mode, err;
    logic [6:0] ac;

    lcd_hd44780_responder #(
        .E_MIN_CYCLES(E_MIN), .BUSY_SHORT(BS), .BUSY_LONG(BL), .POWERUP_CYCLES(PWR)
    ) dut (
        .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_d(lcd_d), .lcd_q(lcd_q), .lcd_q_oe(lcd_q_oe), .busy(busy), .ac(ac),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .two_line(two_line), .inc_mode(inc_mode), .err(err),
        .peek_addr(peek_addr), .peek_data(peek_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    // Reference model: "busy after posedge c" holds iff c < busy_until.
    logic [7:0] m_mem [128];
    logic [6:0] m_ac;
    logic       m_inc, m_two, m_disp, m_cur, m_blink, m_err;
    int         busy_until;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Address stepping viewed as a position on a ring of visible cells.
    function automatic logic [6:0] m_step(input logic [6:0] a, input logic inc);
        int idx;
        if (m_two) begin
            if (a <= 7'h27) idx = int'(a);
            else if (a >= 7'h40 && a <= 7'h67) idx = int'(a) - 'h40 + 40;
            else return inc ? a + 7'd1 : a - 7'd1;
            idx = (idx + (inc ? 1 : 79)) % 80;
            return (idx < 40) ? 7'(idx) : 7'(idx - 40 + 'h40);
        end
        if (a <= 7'h4F) return 7'((int'(a) + (inc ? 1 : 79)) % 80);
        return inc ? a + 7'd1 : a - 7'd1;
    endfunction

    task automatic m_cmd(input logic [7:0] d, input int L);
        int hb;
        hb = -1;
        for (int b = 7; b >= 0; b--) if (d[b] && hb < 0) hb = b;
        case (hb)
            7: begin
                m_ac = d[6:0];
                if (m_two ? !(d[6:0] <= 7'h27 || (d[6:0] >= 7'h40 && d[6:0] <= 7'h67))
                          : !(d[6:0] <= 7'h4F)) m_err = 1'b1;
            end
            5: begin m_two = d[3]; if (!d[4]) m_err = 1'b1; end
            4: if (!d[3]) m_ac = m_step(m_ac, d[2]);
            3: begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
            2: m_inc = d[1];
            1: begin m_ac = 7'h00; busy_until = L + 1 + BL; end
            0: begin
                for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
                m_ac = 7'h00; m_inc = 1'b1; busy_until = L + 1 + BL;
            end
            default: ;
        endcase
    endtask

    task automatic txn(input bit rs, input bit rw, input logic [7:0] d, input int w);
        int L;
        bit idle;
        logic [7:0] e;
        @(negedge clk);
        lcd_e = 1'b1; lcd_rs = rs; lcd_rw = rw; lcd_d = d;
        repeat (w) @(negedge clk);
        L = cyc;
        lcd_e = 1'b0;
        if (rw) begin
            e = rs ? m_mem[m_ac] : {((L - 1) < busy_until), m_ac};
            exp_q.push_back(e);
        end
        idle = (L >= busy_until);
        if (w < E_MIN) m_err = 1'b1;
        else if (rw) begin
            if (rs) begin
                if (idle) m_ac = m_step(m_ac, m_inc);
                else m_err = 1'b1;
            end
        end else if (!idle) m_err = 1'b1;
        else begin
            busy_until = L + 1 + BS;
            if (rs) begin m_mem[m_ac] = d; m_ac = m_step(m_ac, m_inc); end
            else m_cmd(d, L);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        if (cyc < busy_until) begin
            do begin @(negedge clk); n++; end while (busy && n < 2000);
            chk("busy_end_cycle", cyc, busy_until);
        end
    endtask

    task automatic chk_peek(input logic [6:0] a);
        @(negedge clk); peek_addr = a;
        @(negedge clk);
        chk($sformatf("peek_%02h", a), int'(peek_data), int'(m_mem[a]));
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk); rst = 1'b1;
        repeat (hold) @(negedge clk);
        rst = 1'b0;
        m_ac = 7'h00; m_inc = 1'b1; m_two = 1'b0; m_disp = 1'b0; m_cur = 1'b0;
        m_blink = 1'b0; m_err = 1'b0; busy_until = cyc + PWR;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_ac"}, int'(ac), int'(m_ac));
        chk({tag, "_two"}, int'(two_line), int'(m_two));
        chk({tag, "_disp"}, int'(disp_on), int'(m_disp));
        chk({tag, "_cur"}, int'(cursor_on), int'(m_cur));
        chk({tag, "_blink"}, int'(blink_on), int'(m_blink));
        chk({tag, "_inc"}, int'(inc_mode), int'(m_inc));
        chk({tag, "_err"}, int'(err), int'(m_err));
    endtask

    task automatic wr(input bit rs, input logic [7:0] d);
        txn(rs, 1'b0, d, E_MIN + 1);
        wait_idle();
    endtask

    // Monitor: a read completes when the DUT drops lcd_q_oe.
    logic       prev_oe = 1'b0;
    logic [7:0] prev_q = 8'h00;
    logic [7:0] mon_e;
    always @(negedge clk) begin
        if (prev_oe && !lcd_q_oe) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected act=%02h exp=none", prev_q);
            end else begin
                mon_e = exp_q.pop_front();
                if (prev_q !== mon_e) begin
                    errors++;
                    $display("FAIL rd_data act=%02h exp=%02h", prev_q, mon_e);
                end
            end
        end
        prev_oe <= lcd_q_oe;
        prev_q  <= lcd_q;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] str [8];
        int k;
        for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
        do_reset(3);
        chk("rst_busy", int'(busy), 1);
        chk("rst_q", int'(lcd_q), 0);
        chk("rst_q_oe", int'(lcd_q_oe), 0);
        chk_state("rst");
        wait_idle();

        foreach (str[i]) str[i] = 8'h00;
        wr(0, 8'h38); wr(0, 8'h38); wr(0, 8'h06); wr(0, 8'h0C); wr(0, 8'h01);
        chk_state("init");
        for (int a = 0; a < 128; a++) chk_peek(7'(a));

        str[0] = c_DIGIT_BASE + 8'd1; str[1] = c_DIGIT_BASE + 8'd2; str[2] = c_COLON;
        str[3] = c_DIGIT_BASE + 8'd3; str[4] = c_DIGIT_BASE + 8'd4; str[5] = c_COLON;
        str[6] = c_DIGIT_BASE + 8'd5; str[7] = c_DIGIT_BASE + 8'd6;
        for (int i = 0; i < 8; i++) wr(1, str[i]);
        wr(0, 8'h80);
        chk("str_ac", int'(ac), 0);
        for (int i = 0; i < 8; i++) chk_peek(7'(i));
        for (int i = 0; i < 8; i++) txn(1, 1, 8'h00, E_MIN);
        txn(0, 1, 8'h00, E_MIN + 2);

        wr(0, 8'hA7); wr(1, 8'h41); wr(1, 8'h41);
        chk("wrap_ac_41", int'(ac), int'(m_ac));
        chk_peek(7'h27); chk_peek(7'h40);
        wr(0, 8'h04); wr(0, 8'h80); wr(1, 8'h42);
        chk("wrap_ac_67", int'(ac), int'(m_ac));
        wr(0, 8'h06);

        // Clear, then poll BF across the whole execution window.
        txn(0, 0, 8'h01, E_MIN);
        k = 0;
        while (cyc < busy_until + 4 && k < 200) begin
            if (k == 5) txn(1, 0, 8'h55, E_MIN);
            else txn(0, 1, 8'h00, E_MIN);
            k++;
        end
        chk_state("clear");
        chk_peek(7'h00); chk_peek(7'h05);

        // Reset while clear is still filling; fill restarts from address 0.
        wr(0, 8'h8C); wr(1, 8'h58);
        txn(0, 0, 8'h01, E_MIN);
        repeat (6) @(negedge clk);
        do_reset(1);
        chk("fillrst_busy", int'(busy), 1);
        chk_state("fillrst");
        repeat (7) @(negedge clk);
        peek_addr = 7'h0C;
        @(negedge clk);
        chk("fillrst_peek_old", int'(peek_data), 'h58);
        repeat (10) @(negedge clk);
        chk("fillrst_peek_new", int'(peek_data), 'h20);
        wait_idle();
        for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;

        wr(0, 8'h38); wr(0, 8'h0C);
        txn(1, 0, 8'h31, 2);
        repeat (2) @(negedge clk);
        chk_state("short");
        chk_peek(7'h00);
        txn(0, 0, 8'h01, 1);
        wait_idle();
        chk_state("width1");

        for (int n = 0; n < 200; n++) begin
            int w;
            w = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, E_MIN - 1))
                                             : int'($urandom_range(E_MIN, E_MIN + 3));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    if ($urandom_range(0, 4) != 0) wait_idle();
                    txn(1, 0, 8'($urandom_range('h20, 'h7E)), w);
                end
                4, 5: begin
                    case ($urandom_range(0, 7))
                        0: d = 8'h04 | 8'($urandom_range(0, 3));
                        1: d = 8'h08 | 8'($urandom_range(0, 7));
                        2: d = 8'h10 | 8'($urandom_range(0, 15));
                        3: d = 8'h20 | 8'($urandom_range(0, 31));
                        4: d = 8'h80 | 8'($urandom_range(0, 127));
                        5: d = 8'h40 | 8'($urandom_range(0, 63));
                        6: d = 8'h02 | 8'($urandom_range(0, 1));
                        default: d = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h0C;
                    endcase
                    if ($urandom_range(0, 4) != 0) wait_idle();
                    txn(0, 0, d, w);
                end
                6, 7: txn(0, 1, 8'h00, w);
                8: txn(cyc >= busy_until, 1, 8'h00, w);
                default: repeat ($urandom_range(0, 3)) @(negedge clk);
            endcase
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk_state("final");
        for (int i = 0; i < 16; i++) chk_peek(7'($urandom_range(0, 127)));
        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
